// File: rtl/vergoto_mc_pkg.sv
// Shared types and constants for the multi-channel branch/interrupt unit.
// Holds the instruction encoding, word type and fixed trap/IRQ addresses.
package vergoto_mc_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } branch_op_t;

  typedef struct packed {
    logic       is_jump;
    logic       is_mret;
    logic       is_trap;
    logic       is_branch;
    branch_op_t br_op;
  } instruction_t;

  localparam word_t       IRQ_ADDRESS  = 32'h0000_0200;
  localparam word_t       TRAP_ADDRESS = 32'h0000_0300;
  localparam logic [30:0] TRAP_CAUSE   = 31'd11;

endpackage

// File: rtl/vergoto_mc_branch_compare.sv
// Branch condition evaluation: decides whether a conditional branch is taken.
module branch_compare
  import vergoto_mc_pkg::*;
(
  input  instruction_t instr,
  input  word_t        a,
  input  word_t        b,
  output logic         taken
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  always_comb begin
    a_s   = a;
    b_s   = b;
    taken = 1'b0;
    if (instr.is_branch) begin
      case (instr.br_op)
        BR_EQ:   taken = (a == b);
        BR_NE:   taken = (a != b);
        BR_LT:   taken = (a_s < b_s);
        BR_GE:   taken = (a_s >= b_s);
        BR_LTU:  taken = (a < b);
        BR_GEU:  taken = (a >= b);
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/vergoto_mc.sv
// Next-PC selection with prioritised, maskable multi-line interrupts.
// Owns exception state, MEPC, MCAUSE, the interrupt mask and pending bits.
module vergoto_mc
  import vergoto_mc_pkg::*;
#(
  parameter int unsigned          IRQ_COUNT = 4,
  parameter logic [IRQ_COUNT-1:0] IRQ_EDGE  = '0,
  parameter bit                   VECTORED  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [IRQ_COUNT-1:0] irq,
  input  logic                 mask_we,
  input  logic [IRQ_COUNT-1:0] mask_wdata,
  input  instruction_t         instr,
  input  word_t                xs1,
  input  word_t                xs2,
  input  word_t                address,
  input  word_t                pc_incr,
  output word_t                pc_next,
  output logic                 will_jump,
  output logic [IRQ_COUNT-1:0] irq_ack,
  output word_t                mcause,
  output logic                 except_state
);

  function automatic logic [3:0] lowest_set(input logic [IRQ_COUNT-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

  logic                 except_q, except_d;
  word_t                mepc_q, mepc_d;
  word_t                mcause_q, mcause_d;
  logic [IRQ_COUNT-1:0] mask_q, mask_d;
  logic [IRQ_COUNT-1:0] pending_q, pending_d;
  logic [IRQ_COUNT-1:0] irq_prev_q;

  logic                 taken;
  word_t                pc_target;
  logic [IRQ_COUNT-1:0] eligible;
  logic                 accept;
  logic [3:0]           idx;
  word_t                irq_vector;

  branch_compare u_cmp (
    .instr (instr),
    .a     (xs1),
    .b     (xs2),
    .taken (taken)
  );

  always_comb begin
    if (instr.is_mret)
      pc_target = mepc_q;
    else if (instr.is_jump || taken)
      pc_target = address & 32'hFFFF_FFFC;
    else
      pc_target = pc_incr;

    eligible   = pending_q & mask_q;
    accept     = (|eligible) & ~except_q;
    idx        = lowest_set(eligible);
    irq_vector = VECTORED ? (IRQ_ADDRESS + {26'b0, idx, 2'b00}) : IRQ_ADDRESS;

    if (accept)
      pc_next = irq_vector;
    else if (instr.is_trap)
      pc_next = TRAP_ADDRESS;
    else
      pc_next = pc_target;

    for (int i = 0; i < IRQ_COUNT; i++)
      irq_ack[i] = accept & enable & (idx == 4'(i));

    will_jump = instr.is_mret | instr.is_jump | taken | accept | instr.is_trap;
  end

  always_comb begin
    except_d = except_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (enable) begin
      if (instr.is_mret)
        except_d = 1'b0;
      else if (accept || instr.is_trap)
        except_d = 1'b1;
      if (accept || instr.is_trap)
        mepc_d = pc_target;
      if (accept)
        mcause_d = {1'b1, 27'b0, idx};
      else if (instr.is_trap)
        mcause_d = {1'b0, TRAP_CAUSE};
    end

    // Edge lines latch a rising edge until acknowledged; a new edge beats the clear.
    for (int i = 0; i < IRQ_COUNT; i++) begin
      if (IRQ_EDGE[i])
        pending_d[i] = (irq[i] & ~irq_prev_q[i]) | (pending_q[i] & ~irq_ack[i]);
      else
        pending_d[i] = irq[i];
    end

    mask_d = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      except_q   <= 1'b0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mask_q     <= '1;
      pending_q  <= '0;
      irq_prev_q <= '0;
    end else begin
      except_q   <= except_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq;
    end
  end

  assign mcause       = mcause_q;
  assign except_state = except_q;

endmodule
